// File: rtl/spike_rate_decoder.sv
// rtl/spike_rate_decoder.sv - windowed spike counter with first-spike latency and a valid/ready result register
module spike_rate_decoder #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8,
  parameter int LAT_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             spike_in,
  input  logic             rate_ready,
  output logic             rate_valid,
  output logic [CNT_W-1:0] rate_count,
  output logic [LAT_W-1:0] first_lat,
  output logic             overrun,
  output logic             busy
);

  localparam int IDX_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_COUNT = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WINDOW - 1);

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             seen_q, seen_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [LAT_W-1:0] rlat_q, rlat_d;
  logic             ovr_q, ovr_d;

  logic [CNT_W-1:0] win_cnt;
  logic [LAT_W-1:0] win_lat;
  logic             win_seen;
  logic             win_end;
  logic             take;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    seen_d  = seen_q;
    valid_d = valid_q;
    rcnt_d  = rcnt_q;
    rlat_d  = rlat_q;
    ovr_d   = ovr_q;
    win_end = 1'b0;
    take    = valid_q & rate_ready;

    // Window accumulators including the current cycle's spike
    win_cnt  = (spike_in && cnt_q != CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;
    win_lat  = (spike_in && !seen_q) ? LAT_W'(idx_q) : lat_q;
    win_seen = seen_q | spike_in;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_COUNT;
          idx_d   = '0;
          cnt_d   = '0;
          lat_d   = '0;
          seen_d  = 1'b0;
        end
      end
      default: begin
        if (!en) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
          lat_d   = '0;
          seen_d  = 1'b0;
        end else if (idx_q == IDX_LAST) begin
          win_end = 1'b1;
          idx_d   = '0;
          cnt_d   = '0;
          lat_d   = '0;
          seen_d  = 1'b0;
        end else begin
          idx_d  = idx_q + IDX_W'(1);
          cnt_d  = win_cnt;
          lat_d  = win_lat;
          seen_d = win_seen;
        end
      end
    endcase

    // A full register that is not being drained drops the new result
    if (win_end) begin
      if (!valid_q || take) begin
        valid_d = 1'b1;
        rcnt_d  = win_cnt;
        rlat_d  = win_seen ? win_lat : {LAT_W{1'b1}};
        ovr_d   = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (take) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
      seen_q  <= 1'b0;
      valid_q <= 1'b0;
      rcnt_q  <= '0;
      rlat_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      seen_q  <= seen_d;
      valid_q <= valid_d;
      rcnt_q  <= rcnt_d;
      rlat_q  <= rlat_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rate_valid = valid_q;
  assign rate_count = rcnt_q;
  assign first_lat  = rlat_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q == ST_COUNT);

endmodule
